// File: rtl/rom_copy_pkg.sv
// Shared types and defaults for the ROM-to-RAM copy engine.
// Default segments preload the SHA-256 constant tables.
package rom_copy_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_t;

   localparam int SHA_NUM_SEG = 2;
   localparam logic [25:0] SHA_SEG_SRC = {13'd8, 13'd0};
   localparam logic [15:0] SHA_SEG_DST = {8'd64, 8'd0};
   localparam logic [17:0] SHA_SEG_LEN = {9'd64, 9'd8};

   // Field i of width w from a packed table, field 0 in the LSBs.
   function automatic logic [31:0] field(
      input logic [1023:0] vec,
      input int w,
      input int i
   );
      logic [1023:0] s;
      s = vec >> (w * i);
      return s[31:0] & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/rom_copy_seg_seq.sv
// Segment sequencer: walks src/dst/remaining over the segment table,
// skipping zero-length segments without spending a cycle on them.
module rom_copy_seg_seq
   import rom_copy_pkg::*;
#(
   parameter int RAM_AW = 8,
   parameter int ROM_AW = 13,
   parameter int NUM_SEG = SHA_NUM_SEG,
   parameter logic [NUM_SEG*ROM_AW-1:0] SEG_SRC = SHA_SEG_SRC,
   parameter logic [NUM_SEG*RAM_AW-1:0] SEG_DST = SHA_SEG_DST,
   parameter logic [NUM_SEG*(RAM_AW+1)-1:0] SEG_LEN = SHA_SEG_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic              have,
   output logic              last,
   output logic [ROM_AW-1:0] src,
   output logic [RAM_AW-1:0] dst
);

   localparam int IW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam int LW = RAM_AW + 1;

   logic [ROM_AW-1:0] src_tab [NUM_SEG];
   logic [RAM_AW-1:0] dst_tab [NUM_SEG];
   logic [LW-1:0]     len_tab [NUM_SEG];

   for (genvar g = 0; g < NUM_SEG; g++) begin : g_tab
      assign src_tab[g] = ROM_AW'(field(1024'(SEG_SRC), ROM_AW, g));
      assign dst_tab[g] = RAM_AW'(field(1024'(SEG_DST), RAM_AW, g));
      assign len_tab[g] = LW'(field(1024'(SEG_LEN), LW, g));
   end

   logic [IW-1:0]     idx_q, cur_idx;
   logic [ROM_AW-1:0] src_q, cur_src;
   logic [RAM_AW-1:0] dst_q, cur_dst;
   logic [LW-1:0]     rem_q, cur_rem;
   logic              more;

   // rem_q == 0 means segment idx_q is exhausted; look ahead for the next one.
   always_comb begin
      cur_idx = idx_q;
      cur_src = src_q;
      cur_dst = dst_q;
      cur_rem = rem_q;
      have    = 1'b0;
      more    = 1'b0;
      if (rem_q != '0) begin
         have = 1'b1;
      end else begin
         for (int k = NUM_SEG - 1; k >= 0; k--) begin
            if (k > int'(idx_q) && len_tab[k] != '0) begin
               cur_idx = IW'(k);
               cur_src = src_tab[k];
               cur_dst = dst_tab[k];
               cur_rem = len_tab[k];
               have    = 1'b1;
            end
         end
      end
      for (int k = 0; k < NUM_SEG; k++) begin
         if (k > int'(cur_idx) && len_tab[k] != '0) more = 1'b1;
      end
      last = have && (cur_rem == LW'(1)) && !more;
   end

   assign src = cur_src;
   assign dst = cur_dst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         src_q <= '0;
         dst_q <= '0;
         rem_q <= '0;
      end else if (load) begin
         idx_q <= '0;
         src_q <= src_tab[0];
         dst_q <= dst_tab[0];
         rem_q <= len_tab[0];
      end else if (step) begin
         if (cur_rem == LW'(1)) begin
            if (int'(cur_idx) < NUM_SEG - 1) begin
               idx_q <= cur_idx + 1'b1;
               src_q <= src_tab[cur_idx + 1'b1];
               dst_q <= dst_tab[cur_idx + 1'b1];
               rem_q <= len_tab[cur_idx + 1'b1];
            end else begin
               idx_q <= cur_idx;
               rem_q <= '0;
            end
         end else begin
            idx_q <= cur_idx;
            src_q <= cur_src + 1'b1;
            dst_q <= cur_dst + 1'b1;
            rem_q <= cur_rem - 1'b1;
         end
      end
   end

endmodule

// File: rtl/rom_copy_engine.sv
// ROM-to-RAM segment copy engine with a host RAM port that is
// served whenever no copy is in flight.
module rom_copy_engine
   import rom_copy_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RAM_AW = 8,
   parameter int ROM_AW = 13,
   parameter int NUM_SEG = SHA_NUM_SEG,
   parameter logic [NUM_SEG*ROM_AW-1:0] SEG_SRC = SHA_SEG_SRC,
   parameter logic [NUM_SEG*RAM_AW-1:0] SEG_DST = SHA_SEG_DST,
   parameter logic [NUM_SEG*(RAM_AW+1)-1:0] SEG_LEN = SHA_SEG_LEN
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   input  logic              HOST_RE,
   input  logic              HOST_WR,
   input  logic [RAM_AW-1:0] HOST_ADDR,
   input  logic [DATA_W-1:0] HOST_WDATA,
   output logic [DATA_W-1:0] HOST_RDATA,
   output logic              HOST_RVALID,
   output logic              HOST_STALL,
   output logic              ROM_RE,
   output logic [ROM_AW-1:0] ROM_ADDR,
   input  logic [DATA_W-1:0] ROM_RDATA,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic [RAM_AW-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_WDATA,
   input  logic [DATA_W-1:0] RAM_RDATA
);

   state_t state_q, state_d;

   logic              prime_q;
   logic              valid_q;
   logic [RAM_AW-1:0] dst_pipe_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   logic              accept, issue, have, last;
   logic              host_ok, host_rd;
   logic [ROM_AW-1:0] seq_src;
   logic [RAM_AW-1:0] seq_dst;

   rom_copy_seg_seq #(
      .RAM_AW  (RAM_AW),
      .ROM_AW  (ROM_AW),
      .NUM_SEG (NUM_SEG),
      .SEG_SRC (SEG_SRC),
      .SEG_DST (SEG_DST),
      .SEG_LEN (SEG_LEN)
   ) u_seq (
      .clk  (CLK),
      .rst  (RST),
      .load (accept),
      .step (issue),
      .have (have),
      .last (last),
      .src  (seq_src),
      .dst  (seq_dst)
   );

   // First RUN cycle lets the freshly loaded segment settle before reading.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      issue   = 1'b0;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept = START;
            if (START) state_d = RUN;
         end
         RUN: begin
            BUSY  = 1'b1;
            issue = !prime_q && have;
            if (!prime_q && (!have || last)) state_d = DRAIN;
         end
         DRAIN: begin
            BUSY    = 1'b1;
            state_d = FIN;
         end
         FIN: begin
            DONE   = 1'b1;
            accept = START;
            if (START) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ROM_RE   = issue;
   assign ROM_ADDR = seq_src;

   assign host_ok    = !BUSY;
   assign host_rd    = host_ok && HOST_RE && !HOST_WR;
   assign HOST_STALL = BUSY && (HOST_RE || HOST_WR);

   assign RAM_EN    = valid_q || (host_ok && (HOST_RE || HOST_WR));
   assign RAM_WE    = valid_q || (host_ok && HOST_WR);
   assign RAM_ADDR  = valid_q ? dst_pipe_q : HOST_ADDR;
   assign RAM_WDATA = valid_q ? ROM_RDATA : HOST_WDATA;

   assign HOST_RVALID = rvalid_q;
   assign HOST_RDATA  = rvalid_q ? RAM_RDATA : rdata_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         prime_q    <= 1'b0;
         valid_q    <= 1'b0;
         dst_pipe_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q  <= state_d;
         prime_q  <= accept;
         valid_q  <= issue;
         rvalid_q <= host_rd;
         if (issue) dst_pipe_q <= seq_dst;
         if (rvalid_q) rdata_q <= RAM_RDATA;
      end
   end

endmodule

// File: tb/tb_rom_copy_engine.sv
// Bench for rom_copy_engine: three configurations, ROM/RAM models,
// and a schedule-based reference model checked every cycle.
module tb_rom_copy_engine;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start [NI];
   logic        busy [NI];
   logic        done [NI];
   logic        host_re [NI];
   logic        host_wr [NI];
   logic [7:0]  host_addr [NI];
   logic [31:0] host_wdata [NI];
   logic [31:0] host_rdata [NI];
   logic        host_rvalid [NI];
   logic        host_stall [NI];
   logic        rom_re [NI];
   logic [12:0] rom_addr [NI];
   logic [31:0] rom_rdata [NI];
   logic        ram_en [NI];
   logic        ram_we [NI];
   logic [7:0]  ram_addr [NI];
   logic [31:0] ram_wdata [NI];
   logic [31:0] ram_rdata [NI];

   rom_copy_engine dut0 (
      .CLK(clk), .RST(rst), .START(start[0]), .BUSY(busy[0]),
      .DONE(done[0]), .HOST_RE(host_re[0]), .HOST_WR(host_wr[0]),
      .HOST_ADDR(host_addr[0]), .HOST_WDATA(host_wdata[0]),
      .HOST_RDATA(host_rdata[0]), .HOST_RVALID(host_rvalid[0]),
      .HOST_STALL(host_stall[0]), .ROM_RE(rom_re[0]),
      .ROM_ADDR(rom_addr[0]), .ROM_RDATA(rom_rdata[0]),
      .RAM_EN(ram_en[0]), .RAM_WE(ram_we[0]), .RAM_ADDR(ram_addr[0]),
      .RAM_WDATA(ram_wdata[0]), .RAM_RDATA(ram_rdata[0])
   );

   rom_copy_engine #(
      .NUM_SEG(3),
      .SEG_SRC({13'd0, 13'd20, 13'd0}),
      .SEG_DST({8'd0, 8'd254, 8'd0}),
      .SEG_LEN({9'd0, 9'd4, 9'd0})
   ) dut1 (
      .CLK(clk), .RST(rst), .START(start[1]), .BUSY(busy[1]),
      .DONE(done[1]), .HOST_RE(host_re[1]), .HOST_WR(host_wr[1]),
      .HOST_ADDR(host_addr[1]), .HOST_WDATA(host_wdata[1]),
      .HOST_RDATA(host_rdata[1]), .HOST_RVALID(host_rvalid[1]),
      .HOST_STALL(host_stall[1]), .ROM_RE(rom_re[1]),
      .ROM_ADDR(rom_addr[1]), .ROM_RDATA(rom_rdata[1]),
      .RAM_EN(ram_en[1]), .RAM_WE(ram_we[1]), .RAM_ADDR(ram_addr[1]),
      .RAM_WDATA(ram_wdata[1]), .RAM_RDATA(ram_rdata[1])
   );

   rom_copy_engine #(
      .SEG_LEN({9'd0, 9'd0})
   ) dut2 (
      .CLK(clk), .RST(rst), .START(start[2]), .BUSY(busy[2]),
      .DONE(done[2]), .HOST_RE(host_re[2]), .HOST_WR(host_wr[2]),
      .HOST_ADDR(host_addr[2]), .HOST_WDATA(host_wdata[2]),
      .HOST_RDATA(host_rdata[2]), .HOST_RVALID(host_rvalid[2]),
      .HOST_STALL(host_stall[2]), .ROM_RE(rom_re[2]),
      .ROM_ADDR(rom_addr[2]), .ROM_RDATA(rom_rdata[2]),
      .RAM_EN(ram_en[2]), .RAM_WE(ram_we[2]), .RAM_ADDR(ram_addr[2]),
      .RAM_WDATA(ram_wdata[2]), .RAM_RDATA(ram_rdata[2])
   );

   // Segment tables as the bench sees them (unused slots have length 0).
   int seg_src [NI][3] = '{'{0, 8, 0}, '{0, 20, 0}, '{0, 8, 0}};
   int seg_dst [NI][3] = '{'{0, 64, 0}, '{0, 254, 0}, '{0, 64, 0}};
   int seg_len [NI][3] = '{'{8, 64, 0}, '{0, 4, 0}, '{0, 0, 0}};

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [31:0] mem [NI][256];
   logic [31:0] exp_ram [NI][256];
   int we_cnt [NI] = '{0, 0, 0};
   int re_cnt [NI] = '{0, 0, 0};

   logic [12:0] exp_src [NI][128];
   logic [7:0]  exp_dst [NI][128];
   logic [31:0] exp_dat [NI][128];
   int  nw [NI] = '{0, 0, 0};
   int  dl [NI] = '{0, 0, 0};
   int  t0 [NI] = '{0, 0, 0};
   bit  active [NI] = '{0, 0, 0};
   bit  rd_pend [NI] = '{0, 0, 0};
   logic [31:0] rd_exp [NI];

   always @(posedge clk) cyc <= cyc + 1;

   // ROM returns 0x100+addr one cycle after RE; RAM is synchronous.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (rom_re[g]) begin
            rom_rdata[g] <= 32'h100 + 32'(rom_addr[g]);
            re_cnt[g] <= re_cnt[g] + 1;
         end
         if (ram_en[g]) begin
            if (ram_we[g]) begin
               mem[g][ram_addr[g]] <= ram_wdata[g];
               if (busy[g]) we_cnt[g] <= we_cnt[g] + 1;
            end else begin
               ram_rdata[g] <= mem[g][ram_addr[g]];
            end
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected word list: every segment in order, addresses wrapped.
   task automatic build(input int g);
      int n;
      n = 0;
      for (int s = 0; s < 3; s++) begin
         for (int j = 0; j < seg_len[g][s]; j++) begin
            exp_src[g][n] = 13'((seg_src[g][s] + j) % 8192);
            exp_dst[g][n] = 8'((seg_dst[g][s] + j) % 256);
            exp_dat[g][n] = 32'h100 + 32'(exp_src[g][n]);
            n++;
         end
      end
      nw[g] = n;
      dl[g] = (n == 0) ? 3 : n + 2;
   endtask

   // Cycle k after the START edge: reads at 1..N, writes at 2..N+1,
   // DONE from edge D; host served only while not busy.
   always @(negedge clk) begin
      if (!rst) begin
         for (int g = 0; g < NI; g++) begin
            int k;
            bit eb, ed, er, cw, hw, hr;
            k  = cyc - t0[g];
            eb = active[g] && k >= 0 && k < dl[g];
            ed = active[g] && k >= dl[g];
            er = eb && k >= 1 && k <= nw[g];
            cw = eb && k >= 2 && k <= nw[g] + 1;
            hw = !eb && host_wr[g];
            hr = !eb && host_re[g] && !host_wr[g];
            check("busy", 64'(busy[g]), 64'(eb));
            if (!(active[g] && k < 0)) check("done", 64'(done[g]), 64'(ed));
            check("rom_re", 64'(rom_re[g]), 64'(er));
            if (er) check("rom_addr", 64'(rom_addr[g]), 64'(exp_src[g][k-1]));
            check("ram_we", 64'(ram_we[g]), 64'(cw || hw));
            check("ram_en", 64'(ram_en[g]), 64'(cw || hw || hr));
            if (cw) begin
               check("copy_addr", 64'(ram_addr[g]), 64'(exp_dst[g][k-2]));
               check("copy_data", 64'(ram_wdata[g]), 64'(exp_dat[g][k-2]));
               exp_ram[g][exp_dst[g][k-2]] = exp_dat[g][k-2];
            end else if (hw || hr) begin
               check("host_addr", 64'(ram_addr[g]), 64'(host_addr[g]));
               if (hw) begin
                  check("host_wdata", 64'(ram_wdata[g]), 64'(host_wdata[g]));
                  exp_ram[g][host_addr[g]] = host_wdata[g];
               end
            end
            check("stall", 64'(host_stall[g]),
                  64'(eb && (host_re[g] || host_wr[g])));
            check("rvalid", 64'(host_rvalid[g]), 64'(rd_pend[g]));
            if (rd_pend[g]) check("rdata", 64'(host_rdata[g]), 64'(rd_exp[g]));
            rd_pend[g] = hr;
            if (hr) rd_exp[g] = exp_ram[g][host_addr[g]];
         end
      end
   end

   // Caller positions this just after a rising edge.
   task automatic do_start(input int g);
      start[g] = 1'b1;
      t0[g] = cyc + 1;
      build(g);
      active[g] = 1'b1;
      @(posedge clk);
      #1;
      start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, output int e, output int stalls);
      e = -1;
      stalls = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (host_stall[g]) stalls++;
         if (done[g]) begin
            e = cyc;
            break;
         end
      end
      if (e < 0) check("done_timeout", 64'(done[g]), 64'd1);
   endtask

   initial begin
      int e, st, w0, nerr;
      for (int g = 0; g < NI; g++) begin
         start[g] = 1'b0;
         host_re[g] = 1'b0;
         host_wr[g] = 1'b0;
         host_addr[g] = '0;
         host_wdata[g] = '0;
         for (int a = 0; a < 256; a++) begin
            mem[g][a] = 32'hdead_0000 | 32'(a);
            exp_ram[g][a] = 32'hdead_0000 | 32'(a);
         end
      end

      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy[0]), 64'd0);
      check("rst_done", 64'(done[0]), 64'd0);
      check("rst_rom_re", 64'(rom_re[0]), 64'd0);
      check("rst_ram_en", 64'(ram_en[0]), 64'd0);
      check("rst_rvalid", 64'(host_rvalid[0]), 64'd0);
      check("rst_rdata", 64'(host_rdata[0]), 64'd0);
      @(posedge clk);
      #3 rst = 1'b0;

      // Zero-length skip with wrapping destination, and all-empty table.
      @(posedge clk);
      #1;
      do_start(1);
      do_start(2);
      wait_done(2, e, st);
      check("zero_done_edge", 64'(e - t0[2]), 64'd3);
      wait_done(1, e, st);
      check("seg1_done_edge", 64'(e - t0[1]), 64'd6);
      @(negedge clk);
      check("wrap_254", 64'(mem[1][254]), 64'h114);
      check("wrap_255", 64'(mem[1][255]), 64'h115);
      check("wrap_0", 64'(mem[1][0]), 64'h116);
      check("wrap_1", 64'(mem[1][1]), 64'h117);
      check("wrap_253", 64'(mem[1][253]), 64'hdead00fd);
      check("wrap_2", 64'(mem[1][2]), 64'hdead0002);
      check("seg1_writes", 64'(we_cnt[1]), 64'd4);
      check("zero_reads", 64'(re_cnt[2]), 64'd0);
      check("zero_writes", 64'(we_cnt[2]), 64'd0);

      // Default SHA table, with a stray START mid-run.
      w0 = we_cnt[0];
      @(posedge clk);
      #1;
      do_start(0);
      repeat (10) @(posedge clk);
      #1 start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      wait_done(0, e, st);
      check("sha_done_edge", 64'(e - t0[0]), 64'd74);
      @(negedge clk);
      check("sha_writes", 64'(we_cnt[0] - w0), 64'd72);
      check("ram_0", 64'(mem[0][0]), 64'h100);
      check("ram_7", 64'(mem[0][7]), 64'h107);
      check("ram_64", 64'(mem[0][64]), 64'h108);
      check("ram_127", 64'(mem[0][127]), 64'h147);
      nerr = 0;
      for (int a = 8; a < 64; a++)
         if (mem[0][a] !== (32'hdead_0000 | 32'(a))) nerr++;
      check("gap_untouched", 64'(nerr), 64'd0);

      // Host write then read-back, then simultaneous RE+WR.
      @(posedge clk);
      #1;
      host_wr[0] = 1'b1;
      host_addr[0] = 8'd10;
      host_wdata[0] = 32'hcafe_0010;
      @(posedge clk);
      #1;
      host_wr[0] = 1'b0;
      host_re[0] = 1'b1;
      @(posedge clk);
      #1;
      host_re[0] = 1'b0;
      @(negedge clk);
      check("host_rvalid", 64'(host_rvalid[0]), 64'd1);
      check("host_rdata", 64'(host_rdata[0]), 64'hcafe0010);
      @(posedge clk);
      #1;
      host_re[0] = 1'b1;
      host_wr[0] = 1'b1;
      host_addr[0] = 8'd11;
      host_wdata[0] = 32'h0b0b_0b0b;
      @(posedge clk);
      #1;
      host_re[0] = 1'b0;
      host_wr[0] = 1'b0;
      @(negedge clk);
      check("rw_no_rvalid", 64'(host_rvalid[0]), 64'd0);
      check("rw_written", 64'(mem[0][11]), 64'h0b0b0b0b);

      // Restart from DONE with a host write held through the copy.
      w0 = we_cnt[0];
      @(posedge clk);
      #1;
      host_wr[0] = 1'b1;
      host_addr[0] = 8'd200;
      host_wdata[0] = 32'haaaa_00c8;
      do_start(0);
      wait_done(0, e, st);
      check("restart_done_edge", 64'(e - t0[0]), 64'd74);
      check("stall_cycles", 64'(st), 64'd74);
      @(posedge clk);
      #1 host_wr[0] = 1'b0;
      @(negedge clk);
      check("held_write", 64'(mem[0][200]), 64'haaaa00c8);
      check("restart_writes", 64'(we_cnt[0] - w0), 64'd72);

      // Asynchronous reset mid-copy, then a clean full copy.
      @(posedge clk);
      #1;
      do_start(0);
      while (cyc < t0[0] + 30) @(posedge clk);
      #3;
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         active[g] = 1'b0;
         rd_pend[g] = 1'b0;
      end
      #1;
      check("arst_ram_we", 64'(ram_we[0]), 64'd0);
      check("arst_busy", 64'(busy[0]), 64'd0);
      check("arst_done", 64'(done[0]), 64'd0);
      check("arst_rom_re", 64'(rom_re[0]), 64'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      w0 = we_cnt[0];
      @(posedge clk);
      #1;
      do_start(0);
      wait_done(0, e, st);
      check("post_rst_done_edge", 64'(e - t0[0]), 64'd74);
      @(negedge clk);
      check("post_rst_writes", 64'(we_cnt[0] - w0), 64'd72);
      nerr = 0;
      for (int a = 0; a < 8; a++)
         if (mem[0][a] !== 32'h100 + 32'(a)) nerr++;
      for (int a = 64; a < 128; a++)
         if (mem[0][a] !== 32'h108 + 32'(a - 64)) nerr++;
      check("post_rst_image", 64'(nerr), 64'd0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_copy_engine.md
Name: rom_copy_engine

Overview:
Parametrised successor to the ROM-to-RAM memory manager used to preload SHA-256 constants. It copies NUM_SEG ROM segments, each with its own source base, destination base and length, into word RAM at one word per clock through a pipelined ROM read. Outside a copy it arbitrates a host read/write port onto the same RAM. It sits between the core datapath, the constant EEPROM and the working RAM.

Parameters:
DATA_W, 32, RAM/ROM word width
RAM_AW, 8, RAM word-address width
ROM_AW, 13, ROM word-address width
NUM_SEG, 2, number of copy segments (>=1)
SEG_SRC, {13'd8,13'd0}, packed NUM_SEG*ROM_AW ROM start addresses, segment 0 in LSBs
SEG_DST, {8'd64,8'd0}, packed NUM_SEG*RAM_AW RAM start addresses
SEG_LEN, {9'd64,9'd8}, packed NUM_SEG*(RAM_AW+1) word counts; 0 is legal

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset
START  in  1  begin copy when idle or done
BUSY  out  1  copy in progress
DONE  out  1  sticky copy-complete flag
HOST_RE  in  1  host read request
HOST_WR  in  1  host write request
HOST_ADDR  in  RAM_AW  host word address
HOST_WDATA  in  DATA_W  host write data
HOST_RDATA  out  DATA_W  host read data
HOST_RVALID  out  1  HOST_RDATA valid
HOST_STALL  out  1  host request not accepted this cycle
ROM_RE  out  1  ROM read enable
ROM_ADDR  out  ROM_AW  ROM word address
ROM_RDATA  in  DATA_W  ROM data, valid 1 cycle after ROM_RE
RAM_EN  out  1  RAM access enable
RAM_WE  out  1  RAM write enable
RAM_ADDR  out  RAM_AW  RAM word address
RAM_WDATA  out  DATA_W  RAM write data
RAM_RDATA  in  DATA_W  RAM data, valid 1 cycle after read

Behaviour:
- One clock CLK; RST is asynchronous and active-high. On RST: state IDLE, BUSY=0, DONE=0, HOST_RVALID=0, HOST_RDATA=0, pipeline valid=0, so ROM_RE=RAM_WE=RAM_EN=0 immediately.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE, or FIN with DONE=1: START=1 at an edge loads seg index 0 with its src, dst and remaining count, clears DONE, sets BUSY, and moves to RUN. START in RUN or DRAIN is ignored.
- RUN: a segment with remaining=0 is skipped in zero cycles; the index advances combinationally to the next nonzero segment. Each cycle ROM_RE=1 and ROM_ADDR=src; pipeline register captures dst and sets valid. Then src+1, dst+1 (mod 2^RAM_AW), remaining-1. At remaining=1 it advances segment. After the last word it goes to DRAIN. If all lengths are 0, it goes RUN->DRAIN with no ROM reads.
- Write stage: when valid=1, RAM_EN=RAM_WE=1, RAM_ADDR=dst_pipe, RAM_WDATA=ROM_RDATA.
- DRAIN: one cycle for the final write, then FIN. Entering FIN: BUSY=0, DONE=1. DONE stays high until the next START or RST.
- Latency with total words N>0: START sampled at edge 0 -> ROM reads at cycles 1..N -> RAM writes at cycles 2..N+1 -> DONE=1 from edge N+2. Throughput is 1 word/cycle with no bubbles across segment boundaries.
- Overlapping destinations: the later write wins. Source addresses wrap mod 2^ROM_AW.
- Host port when BUSY=0:
  - HOST_WR drives a RAM write the same cycle.
  - HOST_RE drives a RAM read; HOST_RVALID pulses 1 cycle later and HOST_RDATA is registered from RAM_RDATA.
  - RE and WR together: the write is performed, no RVALID.
- Host port when BUSY=1: HOST_STALL = HOST_RE|HOST_WR. The request is not performed; the host holds it.
- START and a host request in the same IDLE cycle: the host access is performed and the copy begins next cycle.
- RST mid-copy abandons the copy; RAM contents are undefined for the partial segment.

Decomposition:
- Package rom_copy_pkg: FSM state enum, SHA-256 default segment constants, and a function extracting field i from a packed parameter vector.
- One sub-module, rom_copy_seg_seq: segment index/src/dst/remaining sequencer with zero-length skip. The top holds the FSM, write pipeline and host arbitration.

Test Plan:
- Defaults, ROM[i]=i+0x100, START pulse -> 72 writes: RAM[0..7]=0x100..0x107, RAM[64..127]=0x108..0x147. DONE at edge 74; RAM[8..63] untouched.
- NUM_SEG=3, lengths {0,4,0}, seg1 src 20, dst 250 -> writes to 250..253; dst wraps is not needed. Repeat with dst 254 -> writes 254,255,0,1, DONE at edge 6.
- HOST_WR held during copy -> HOST_STALL=1 and no RAM host write until BUSY falls. The write lands the cycle after; readback RVALID comes exactly 1 cycle after RE.
- START re-pulsed mid-RUN -> ignored, exactly 72 writes. START while DONE=1 -> DONE clears next edge and the copy repeats.
- RST asserted asynchronously between edges at cycle 30 -> RAM_WE and BUSY drop immediately, DONE=0. A new START completes the full copy correctly.
- All SEG_LEN=0 -> no ROM_RE, no RAM_WE, DONE=1 at edge 3.
